// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin APB interconnect that lets CPU_NB manager ports
// share a single APB subordinate. Only one transfer is in flight downstream.
// Managers that are not granted are held in their ACCESS phase with pready low.
//
// Bundle layout (packed, MSB first):
//   request  = {paddr[ADDR_W-1:0], pwrite, pwdata[DATA_W-1:0]}
//   response = {pslverr, prdata[DATA_W-1:0]}
// Port i occupies slice [i*W +: W] of the flattened upstream vectors.

module apb_rr_arbiter #(
  parameter int CPU_NB = 4,
  parameter int IDX_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REQ_W  = ADDR_W + 1 + DATA_W,
  parameter int RESP_W = DATA_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CPU_NB*REQ_W-1:0]  i_apb_s_req,
  output logic [CPU_NB*RESP_W-1:0] o_apb_s_resp,
  input  logic [CPU_NB-1:0]        i_apb_s_psel,
  input  logic [CPU_NB-1:0]        i_apb_s_penable,
  output logic [CPU_NB-1:0]        o_apb_s_pready,
  output logic [REQ_W-1:0]         o_apb_m_req,
  input  logic [RESP_W-1:0]        i_apb_m_resp,
  output logic                     o_apb_m_psel,
  output logic                     o_apb_m_penable,
  input  logic                     i_apb_m_pready,
  output logic                     o_grant_valid,
  output logic [IDX_W-1:0]         o_grant_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_m_psel;
  logic               r_m_penable;
  logic               r_grant_valid;

  logic               w_done;
  logic [IDX_W-1:0]   w_ptr_inc;
  logic [IDX_W-1:0]   w_pick_ptr;
  logic [CPU_NB-1:0]  w_cand;
  logic [IDX_W:0]     w_pick;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [REQ_W-1:0]   w_req_sel;

  // First requester found scanning base, base+1, ... modulo CPU_NB.
  // Result is {found, index}; index is 0 when nothing is requesting.
  function automatic logic [IDX_W:0] rr_pick(input logic [CPU_NB-1:0] req,
                                             input logic [IDX_W-1:0]  base);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cidx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CPU_NB; k++) begin
      cand = int'(base) + k;
      if (cand >= CPU_NB) cand = cand - CPU_NB;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
    return {found, idx};
  endfunction

  // A transfer completes when the subordinate answers during ACCESS.
  assign w_done = (r_state == ST_ACCESS) && i_apb_m_pready;

  // Pointer that follows the current owner; this is what rr_ptr becomes on completion.
  assign w_ptr_inc = (r_grant_idx == IDX_W'(CPU_NB - 1)) ? '0 : r_grant_idx + 1'b1;

  // On completion the new pointer is used immediately, so back-to-back grants
  // see the rotated priority in the same cycle the owner finishes.
  assign w_pick_ptr = w_done ? w_ptr_inc : r_rr_ptr;

  // Mask the finishing owner so a manager re-requesting in its own completion
  // cycle cannot win twice in a row.
  always_comb begin
    w_cand = i_apb_s_psel;
    for (int i = 0; i < CPU_NB; i++) begin
      if (w_done && (r_grant_idx == IDX_W'(i))) w_cand[i] = 1'b0;
    end
  end

  assign w_pick     = rr_pick(w_cand, w_pick_ptr);
  assign w_pick_vld = w_pick[IDX_W];
  assign w_pick_idx = w_pick[IDX_W-1:0];

  // Live mux of the owner's request bundle; the manager holds it stable until pready.
  always_comb begin
    w_req_sel = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (r_grant_idx == IDX_W'(i)) w_req_sel = i_apb_s_req[i*REQ_W +: REQ_W];
    end
  end

  // Transfer sequencing: arbitration, SETUP/ACCESS phasing and priority rotation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_m_psel      <= 1'b0;
      r_m_penable   <= 1'b0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant_idx   <= w_pick_idx;
            r_state       <= ST_SETUP;
            r_m_psel      <= 1'b1;
            r_m_penable   <= 1'b0;
            r_grant_valid <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state     <= ST_ACCESS;
          r_m_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (i_apb_m_pready) begin
            r_rr_ptr <= w_ptr_inc;
            if (w_pick_vld) begin
              r_grant_idx <= w_pick_idx;
              r_state     <= ST_SETUP;
              r_m_penable <= 1'b0;
            end else begin
              r_grant_idx   <= '0;
              r_state       <= ST_IDLE;
              r_m_psel      <= 1'b0;
              r_m_penable   <= 1'b0;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant_idx   <= '0;
          r_m_psel      <= 1'b0;
          r_m_penable   <= 1'b0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  // Completion handshake back to the owner only; everyone else sees zeros.
  always_comb begin
    o_apb_s_pready = '0;
    o_apb_s_resp   = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (w_done && (r_grant_idx == IDX_W'(i))) begin
        o_apb_s_pready[i]                   = 1'b1;
        o_apb_s_resp[i*RESP_W +: RESP_W]    = i_apb_m_resp;
      end
    end
  end

  assign o_apb_m_req     = r_m_psel ? w_req_sel : '0;
  assign o_apb_m_psel    = r_m_psel;
  assign o_apb_m_penable = r_m_penable;
  assign o_grant_valid   = r_grant_valid;
  assign o_grant_idx     = r_grant_idx;

  // The owner must keep psel asserted until it has seen pready.
  a_psel_held: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != ST_IDLE) |-> i_apb_s_psel[r_grant_idx])
    else $error("granted manager dropped psel before pready");

  // By the time the downstream ACCESS runs, the owner is in its own ACCESS phase.
  a_penable_owner: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_ACCESS) |-> i_apb_s_penable[r_grant_idx])
    else $error("granted manager not in ACCESS phase during downstream ACCESS");

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Round-robin APB interconnect that lets CPU_NB manager ports (one per cpu) share a single APB subordinate (the shared memory). It sits between the gen_cpu array and one memory port. It owns the downstream SETUP/ACCESS sequencing and holds non-granted managers in their ACCESS phase with pready low. Exactly one transfer is in flight downstream at any time.

Parameters:
CPU_NB, 4, number of upstream manager ports (>=1)
IDX_W, $clog2(CPU_NB) (min 1), width of grant index

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_apb_s_req  in  apb_req_t[CPU_NB]  upstream request bundles (addr/write/wdata)
o_apb_s_resp  out  apb_resp_t[CPU_NB]  upstream response bundles
i_apb_s_psel  in  bit[CPU_NB]  upstream psel
i_apb_s_penable  in  bit[CPU_NB]  upstream penable (monitored only)
o_apb_s_pready  out  bit[CPU_NB]  upstream pready
o_apb_m_req  out  apb_req_t  downstream request bundle
i_apb_m_resp  in  apb_resp_t  downstream response bundle
o_apb_m_psel  out  1  downstream psel
o_apb_m_penable  out  1  downstream penable
i_apb_m_pready  in  1  downstream pready
o_grant_valid  out  1  transfer owned (SETUP or ACCESS)
o_grant_idx  out  IDX_W  current owner index

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low.
- Reset (rst_n low at a clk edge, including mid-transfer): state=IDLE, rr_ptr=0, grant_idx=0. Outputs while in IDLE/reset: o_apb_m_psel=0, o_apb_m_penable=0, o_apb_m_req='0, all o_apb_s_pready=0, all o_apb_s_resp='0, o_grant_valid=0, o_grant_idx=0. A transfer aborted by reset is not replayed.
- FSM states: IDLE, SETUP, ACCESS. State, grant_idx and rr_ptr are registered.
- Arbitration (combinational pick): the first index i with i_apb_s_psel[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap modulo CPU_NB.
- IDLE: if any psel is high, latch grant_idx=pick and go to SETUP. Otherwise stay in IDLE.
- SETUP: o_apb_m_psel=1, o_apb_m_penable=0, o_apb_m_req=i_apb_s_req[grant_idx]. Always go to ACCESS next cycle.
- ACCESS: o_apb_m_psel=1, o_apb_m_penable=1, o_apb_m_req=i_apb_s_req[grant_idx].
  - While i_apb_m_pready=0, stay in ACCESS (unbounded wait states).
  - When i_apb_m_pready=1, in the same cycle: o_apb_s_pready[grant_idx]=1 and o_apb_s_resp[grant_idx]=i_apb_m_resp (combinational pass-through).
  - Also on that cycle: rr_ptr <= (grant_idx+1) mod CPU_NB.
- Back-to-back on completion: the winner's psel is masked for that cycle. If any other psel is high, pick among the others using the new rr_ptr, latch the grant and go directly to SETUP. Otherwise go to IDLE.
- Minimum downstream transfer is 2 cycles. Upstream latency from psel rise is 3 cycles with no contention (IDLE, SETUP, ACCESS+pready). There are no idle bubbles between back-to-back grants.
- Non-granted ports: o_apb_s_pready=0 and o_apb_s_resp='0 at all times.
- Request capture: the bundle is not captured; it is muxed live from the granted port. APB requires the manager to hold it stable until pready.
- Simultaneous requests: resolved only by the rotating priority. A port requesting in the same cycle as completion competes normally. Fairness: a continuously requesting port waits at most CPU_NB-1 transfers.
- Protocol check (simulation assertion only, no functional effect): a granted port must not drop psel before its pready.
- CPU_NB=1: degenerates to a pass-through with registered phasing; rr_ptr stays 0.

Test Plan:
- Reset values: hold rst_n=0 3 cycles with all psel=1 -> all outputs 0/'0. Release -> SETUP in cycle 1, grant_idx=0.
- Single requester: port 2 psel at cycle 0, memory pready=1 immediately -> m_psel cycles 1-2, m_penable cycle 2, o_apb_s_pready[2]=1 in cycle 2 with resp copied. Then IDLE, rr_ptr=3.
- Full contention: all 4 psel held high and re-asserted after each pready -> grant order 0,1,2,3,0. Each downstream transfer is 2 cycles with no IDLE between grants.
- Wait states: pready low for 5 ACCESS cycles -> m_req/m_psel/m_penable stable for 6 cycles. Other ports see pready=0 throughout.
- Wrap and masking: rr_ptr=3 with ports 1 and 3 requesting -> 3 granted, then 1. Port 3 re-asserts psel in its completion cycle -> port 1 still goes first.
- Reset mid-ACCESS: rst_n=0 while in ACCESS with pready=0 -> next cycle m_psel=0, pready never issued, rr_ptr=0. A new request is granted from index 0.
